// File: rtl/ram_dual_arbiter.sv
// ram_dual_arbiter
//   Round-robin arbiter that shares one 2**ADDR_WIDTH x DATA_WIDTH dual-port
//   RAM with a registered read between two requesters. The RAM lives outside
//   this block. Its read and write clocks are both tied to `clock`.
//   The current owner may keep the RAM for up to MAX_BURST consecutive grants
//   while the other requester waits. It keeps going past that limit only when
//   nobody else wants the RAM.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   reqN, weN             requester N access request, write(1)/read(0)
//   addrN, wdataN         requester N address and write data
//   gntN                  access accepted this cycle (combinational)
//   rvalidN, rdataN       read return, one cycle after the granted read
//   ram_data, ram_we      RAM write data and write enable
//   ram_write_addr        RAM write address
//   ram_read_addr         RAM read address
//   ram_q                 RAM registered read data
module ram_dual_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {OWN_NONE, OWN0, OWN1} owner_t;

  owner_t                owner_q, owner_d;
  logic                  last_q, last_d;
  logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
  logic                  rd_pend0_q, rd_pend0_d;
  logic                  rd_pend1_q, rd_pend1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  sel0, sel1;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q     <= OWN_NONE;
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
      rd_pend0_q  <= 1'b0;
      rd_pend1_q  <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend0_q  <= rd_pend0_d;
      rd_pend1_q  <= rd_pend1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  // Grant decision and next state
  always_comb begin
    sel0        = 1'b0;
    sel1        = 1'b0;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (!reset) begin
      case (owner_q)
        OWN0: begin
          if (req0 && (burst_cnt_q < CNT_MAX)) begin
            sel0        = 1'b1;
            burst_cnt_d = burst_cnt_q + CNT_ONE;
          end else if (req0 && !req1) begin
            // Burst limit reached but nobody waiting: start a fresh burst.
            sel0        = 1'b1;
            burst_cnt_d = CNT_ONE;
          end else if (req1) begin
            sel1        = 1'b1;
            owner_d     = OWN1;
            burst_cnt_d = CNT_ONE;
          end else begin
            owner_d     = OWN_NONE;
            burst_cnt_d = '0;
          end
        end
        OWN1: begin
          if (req1 && (burst_cnt_q < CNT_MAX)) begin
            sel1        = 1'b1;
            burst_cnt_d = burst_cnt_q + CNT_ONE;
          end else if (req1 && !req0) begin
            sel1        = 1'b1;
            burst_cnt_d = CNT_ONE;
          end else if (req0) begin
            sel0        = 1'b1;
            owner_d     = OWN0;
            burst_cnt_d = CNT_ONE;
          end else begin
            owner_d     = OWN_NONE;
            burst_cnt_d = '0;
          end
        end
        default: begin
          // Tie from idle goes to whoever was not served last.
          if (req0 && (!req1 || last_q)) begin
            sel0        = 1'b1;
            owner_d     = OWN0;
            burst_cnt_d = CNT_ONE;
          end else if (req1) begin
            sel1        = 1'b1;
            owner_d     = OWN1;
            burst_cnt_d = CNT_ONE;
          end
        end
      endcase
    end

    last_d = last_q;
    if (sel0) last_d = 1'b0;
    if (sel1) last_d = 1'b1;

    rd_pend0_d = sel0 & ~we0;
    rd_pend1_d = sel1 & ~we1;
    // rdata follows ram_q during the return cycle and holds it afterwards.
    rdata0_d = rd_pend0_q ? ram_q : rdata0_q;
    rdata1_d = rd_pend1_q ? ram_q : rdata1_q;

    // RAM address/data hold their last driven value while idle.
    addr_d = addr_q;
    data_d = data_q;
    if (sel0) begin
      addr_d = addr0;
      data_d = wdata0;
    end else if (sel1) begin
      addr_d = addr1;
      data_d = wdata1;
    end
  end

  // Outputs. Returns are masked in the reset cycle so a pending read never
  // surfaces once reset is seen.
  always_comb begin
    gnt0           = sel0;
    gnt1           = sel1;
    ram_we         = (sel0 & we0) | (sel1 & we1);
    ram_write_addr = addr_d;
    ram_read_addr  = addr_d;
    ram_data       = data_d;
    rvalid0        = rd_pend0_q & ~reset;
    rvalid1        = rd_pend1_q & ~reset;
    rdata0         = reset ? '0 : rdata0_d;
    rdata1         = reset ? '0 : rdata1_d;
  end

endmodule
